// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler for a 5-stage MIPS-style pipeline.
// A 3-entry shift-register scoreboard tracks in-flight destinations (EX/MEM/WB).
module hazard_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        issue,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  typedef struct packed {
    logic       rs_used;
    logic [4:0] rs;
    logic       rt_used;
    logic [4:0] rt;
    logic       dest_used;
    logic [4:0] dest;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t    d;
    logic [5:0] opcode;
    logic [5:0] funct;
    d      = '0;
    opcode = instr[31:26];
    funct  = instr[5:0];
    d.rs   = instr[25:21];
    d.rt   = instr[20:16];
    if (instr != 32'h0000_0000) begin
      case (opcode)
        6'h00: begin
          // Shifts take their operand from rt; the rs field is don't-care.
          d.rs_used   = !(funct == 6'h00 || funct == 6'h02);
          d.rt_used   = 1'b1;
          d.dest_used = 1'b1;
          d.dest      = instr[15:11];
        end
        6'h08, 6'h09, 6'h23, 6'h21, 6'h25: begin
          d.rs_used   = 1'b1;
          d.dest_used = 1'b1;
          d.dest      = instr[20:16];
        end
        6'h2b, 6'h04: begin
          d.rs_used = 1'b1;
          d.rt_used = 1'b1;
        end
        default: ;
      endcase
    end
    // $0 is hard-wired: never a producer and never a real dependence.
    if (d.rs == 5'd0)   d.rs_used   = 1'b0;
    if (d.rt == 5'd0)   d.rt_used   = 1'b0;
    if (d.dest == 5'd0) d.dest_used = 1'b0;
    return d;
  endfunction

  decode_t         dec;
  sb_entry_t [2:0] sb;
  logic            hazard;

  assign dec = decode(id_instr);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb[i].valid &&
          ((dec.rs_used && dec.rs == sb[i].dest) ||
           (dec.rt_used && dec.rt == sb[i].dest)))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid;
  end

  // Gating by reset keeps issue low while the block is held in reset.
  assign flush  = ex_branch_taken;
  assign stall  = reset & id_valid & hazard & ~ex_branch_taken;
  assign issue  = reset & id_valid & ~hazard & ~ex_branch_taken;
  assign bubble = ~issue;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < 3; i++) begin
      if (sb[i].valid) busy_mask[sb[i].dest] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all entries shift on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb <= '0;
    end else begin
      sb[2]       <= sb[1];
      sb[1]       <= sb[0];
      sb[0].valid <= issue & dec.dest_used;
      sb[0].dest  <= dec.dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-003 id_valid  input  1  decode stage holds a valid instruction.
REQ-004 id_instr  input  32  instruction word in decode (MIPS encoding, big-endian field layout).
REQ-005 ex_branch_taken  input  1  beq in EX resolved taken this cycle.
REQ-006 stall  output  1  hold PC and IF/ID register this cycle.
REQ-007 bubble  output  1  insert all-zero NOP into ID/EX this cycle.
REQ-008 flush  output  1  squash IF/ID contents this cycle.
REQ-009 issue  output  1  decode instruction advances to EX this cycle.
REQ-010 busy_mask  output  32  bit n=1: register $n has a pending write.
REQ-011 stall_count  output  16  total stall cycles since reset.

Function
REQ-012 Source/dest decode SHALL follow opcode = id_instr[31:26]:
- all-zero word (NOP): no sources, no dest.
- opcode 0x00, funct 0x00/0x02 (sll/srl): source rt; dest rd.
- opcode 0x00, any other funct: sources rs, rt; dest rd.
- 0x08/0x09 (addi/addiu), 0x23/0x21/0x25 (lw/lh/lhu): source rs; dest rt.
- 0x2b (sw), 0x04 (beq): sources rs, rt; no dest.
- any other opcode: no sources, no dest.
REQ-013 Register $0 SHALL never be a tracked dest and never cause a hazard as a source.
REQ-014 Scoreboard SHALL be a 3-entry shift register (E0=EX, E1=MEM, E2=WB), each entry holding valid + 5-bit dest.
REQ-015 Each clk edge: E2<=E1, E1<=E0, E0<=dest of issued instruction if issue=1 and dest exists, else invalid.
REQ-016 hazard SHALL be 1 when id_valid=1 and any decoded source matches the dest of a valid scoreboard entry.
REQ-017 Outputs SHALL be combinational from registered scoreboard and current inputs:
- flush = ex_branch_taken.
- stall = id_valid & hazard & ~ex_branch_taken.
- issue = id_valid & ~hazard & ~ex_branch_taken.
- bubble = ~issue.
REQ-018 Priority: flush over stall; stall and flush SHALL never both be 1.
REQ-019 Dependent instruction SHALL stall until the producer has left E2; back-to-back dependence costs exactly 3 stall cycles; 3 intervening independent instructions or NOPs cost 0.
REQ-020 busy_mask[n] = OR over valid entries of (dest==n); busy_mask[0] always 0.
REQ-021 stall_count SHALL increment by 1 on each clk edge where stall=1, saturate at 0xFFFF, never wrap.
REQ-022 id_valid=0: stall=0, issue=0, bubble=1; scoreboard still shifts.

Reset
REQ-023 While reset=0: all scoreboard entries invalid, busy_mask=0, stall_count=0, stall=0, issue=0, bubble=1, flush=ex_branch_taken.
REQ-024 Reset asserted mid-stall SHALL drop pending hazards immediately; first edge after release operates on an empty scoreboard.

Verification
REQ-025 0x200a000a (addi $10,$0,10) issued, then 0x018a5820 (add $11,$12,$10) held in ID -> stall=1 for 3 cycles, issue=1 on 4th; stall_count=3.
REQ-026 0x200a000a, three 0x00000000, then 0x018a5820 -> stall never 1; busy_mask=0x00000400 for the 3 cycles after addi issues.
REQ-027 0x20000005 (addi $0,$0,5), then 0x0010a840 (sll $21,$16,1) -> no stall; busy_mask stays 0; rs field of sll ignored.
REQ-028 Hazard pending in ID with ex_branch_taken=1 -> flush=1, stall=0, bubble=1, issue=0; stall_count unchanged that edge.
REQ-029 reset=0 pulsed during a 3-cycle stall -> busy_mask=0 and stall=0 without a clk edge; held instruction issues on first cycle after release.
